effects_chain: RTL and testbench
================================

# effects_chain

Parametrised successor to the fixed two-latch distortion path: a three-stage, valid-qualified sample pipeline with Q-format gain, selectable hard/soft clipping and a hold-time noise gate. Sits between the ADC sample source and the DAC/output formatter, one sample per `in_valid` strobe. Runs at the system clock, sample rate arbitrary, and accepts back-to-back samples. Configuration is snapshotted per sample, so the player can change knobs mid-stream without producing glitches.

## Interface
- `DATA_W`, 16: sample width, signed two's complement
- `GAIN_W`, 11: gain width, unsigned
- `GAIN_FRAC`, 8: gain fractional bits (256 = unity at default)
- `HOLD_SAMPLES`, 256: consecutive below-threshold samples before the gate closes; ≥1

- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  synchronous reset, active-high
- `in_valid`  in  1  sample strobe
- `in_sample`  in  DATA_W  signed input sample
- `gain`  in  GAIN_W  unsigned Q(GAIN_W-GAIN_FRAC).GAIN_FRAC gain
- `mode`  in  2  00 bypass, 01 hard clip, 10 soft clip, 11 = hard clip
- `gate_thresh`  in  DATA_W-1  unsigned magnitude threshold; 0 disables the gate
- `out_valid`  out  1  output strobe
- `out_sample`  out  DATA_W  signed processed sample
- `clip_flag`  out  1  saturation/knee was applied to this output sample
- `gate_open`  out  1  gate state for this output sample

## Operation
- Stage 1 (on `in_valid`): register the sample and snapshot `gain`, `mode` and `gate_thresh`. Compute `mag = |x|`, with -2^(DATA_W-1) mapped to 2^(DATA_W-1)-1. Update the gate.
- Gate counter `cnt` (0..HOLD_SAMPLES, saturating):
  - `mag ≥ thresh` or `thresh == 0`: `cnt` goes to 0.
  - Otherwise: `cnt` increments.
  - Gate is closed when the updated `cnt == HOLD_SAMPLES`. The sample that reaches HOLD is itself muted.
  - A sample at or above threshold reopens the gate on that same sample.
- Stage 2: `p = x * gain`, full width DATA_W+GAIN_W+1 signed. Then `y = p >>> GAIN_FRAC`, an arithmetic shift that floors toward -∞.
- Stage 3, by mode:
  - Hard: clamp y to ±(2^(DATA_W-1)-1). The output range is symmetric, so -2^(DATA_W-1) is never produced.
  - Soft:
    - KNEE = 2^(DATA_W-2).
    - If `|y| ≤ KNEE`, pass y.
    - Otherwise the output is sign(y)·min(KNEE + ((|y|-KNEE)>>2), 2^(DATA_W-1)-1). The operation works on magnitude, so it is odd-symmetric.
  - Bypass: output = stage-1 sample unchanged. Gain, clip and gate muting are skipped. The gate counter still updates, and `gate_open` reports its state.
  - `clip_flag` = 1 when the clamp (hard) or the knee (soft) altered the value. It is always 0 in bypass.
  - Gate closed (non-bypass): `out_sample` = 0 and `clip_flag` = 0.
- There is no backpressure. Every accepted sample produces exactly one output.

## Timing
- Latency is 3 cycles: `in_valid` at cycle T gives `out_valid` at T+3, with `out_sample`, `clip_flag` and `gate_open` aligned to it.
- Throughput is 1 sample/cycle. Back-to-back and sparse strobes are both handled, and bubbles propagate unchanged.
- `out_sample`, `clip_flag` and `gate_open` hold their value between strobes.
- Config changes take effect for the first sample whose `in_valid` coincides with or follows the change. In-flight samples keep their snapshot.
- Reset state:
  - All stage valids = 0, `out_valid` = 0, `out_sample` = 0, `clip_flag` = 0.
  - `gate_open` = 1, `cnt` = 0.
- Reset mid-stream discards in-flight samples: no `out_valid` is produced for them. A sample with `in_valid` in the reset cycle is ignored.
- A `gate_thresh` change while the gate is closed does not clear `cnt`. Only an at-or-above-threshold sample does.

## Structure
- Package `effects_pkg`:
  - `effect_mode_t` enum (BYPASS, HARD, SOFT, RSVD)
  - saturate/magnitude functions parametrised on width
- Sub-module `noise_gate`: magnitude, threshold compare and hold counter. It outputs the per-sample `open` status, pipelined alongside the data path.
- The top-level contains the stage registers, the gain multiply and the clip logic.

## Test plan
All scenarios use default parameters except where noted.
- Unity gain 256, hard mode, samples 1000, -1000, 32767: outputs 1000, -1000, 32767, each at T+3, `clip_flag` = 0.
- Gain 512, hard mode, samples 1000, 20000, -32768: outputs 2000, 32767, -32767, with `clip_flag` = 0, 1, 1.
- Gain 512, soft mode, samples 12000, -12000, 8000: outputs 18288, -18288, 16000, with `clip_flag` = 1, 1, 0. Gain 128 with input -1 gives -1 (floor).
- `HOLD_SAMPLES` = 4, thresh 100, hard mode, unity gain:
  - Input 50 ×5 gives outputs 50, 50, 50, 0, 0, with `gate_open` 1, 1, 1, 0, 0.
  - A following input 200 gives output 200 with `gate_open` = 1.
- Back-to-back strobes with gain changed from 256 to 512 at cycle 2: samples before the change come out at unity gain and samples from the change on come out doubled, with no dropped or duplicated `out_valid`.
- `rst` asserted 1 cycle after two accepted samples: no `out_valid` follows. All outputs read reset values, and the gate is open with `cnt` = 0.

Source files
------------

// File: rtl/effects_pkg.sv
// effects_pkg: shared mode encoding and width-generic saturate/magnitude helpers
// Revision 1.0
`default_nettype none

package effects_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'b00,
    HARD   = 2'b01,
    SOFT   = 2'b10,
    RSVD   = 2'b11
  } effect_mode_t;

  // Widths up to 32 bits; w is the target signed width.
  function automatic logic signed [31:0] sat_sym(input logic signed [31:0] v, input int w);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (w - 1)) - 32'sd1;
    if (v > lim)       return lim;
    else if (v < -lim) return -lim;
    else               return v;
  endfunction

  function automatic logic [31:0] mag_sym(input logic signed [31:0] v, input int w);
    logic signed [31:0] a;
    a = (v < 0) ? -v : v;
    return 32'(sat_sym(a, w));
  endfunction

endpackage

`default_nettype wire

// File: rtl/noise_gate.sv
// noise_gate: per-sample magnitude compare with saturating hold counter
// Revision 1.0
`default_nettype none

module noise_gate
  import effects_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int HOLD_SAMPLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-2:0] thresh,
  output logic              open
);

  localparam int CNT_W = $clog2(HOLD_SAMPLES + 1);
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_SAMPLES);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [DATA_W-2:0] mag;

  always_comb begin
    mag = (DATA_W-1)'(mag_sym(32'($signed(sample)), DATA_W));
    cnt_next = cnt;
    if (thresh == '0 || mag >= thresh)
      cnt_next = '0;
    else if (cnt != HOLD)
      cnt_next = cnt + CNT_W'(1);
  end

  // The sample that brings the counter to HOLD is already muted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      open <= 1'b1;
    end else if (valid) begin
      cnt  <= cnt_next;
      open <= (cnt_next != HOLD);
    end
  end

endmodule

`default_nettype wire

// File: rtl/effects_chain.sv
// effects_chain: 3-stage gain / hard-soft clip / noise-gate sample pipeline
// Revision 1.0
`default_nettype none

module effects_chain
  import effects_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int GAIN_W       = 11,
  parameter int GAIN_FRAC    = 8,
  parameter int HOLD_SAMPLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sample,
  input  logic [GAIN_W-1:0] gain,
  input  logic [1:0]        mode,
  input  logic [DATA_W-2:0] gate_thresh,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_sample,
  output logic              clip_flag,
  output logic              gate_open
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam logic signed [31:0] LIM  = (32'sd1 <<< (DATA_W - 1)) - 32'sd1;
  localparam logic signed [31:0] KNEE = 32'sd1 <<< (DATA_W - 2);

  logic                     s1_valid, s2_valid;
  logic signed [DATA_W-1:0] s1_x, s2_x;
  logic [GAIN_W-1:0]        s1_gain;
  effect_mode_t             s1_mode, s2_mode;
  logic                     s1_open, s2_open;
  logic signed [PROD_W-1:0] prod, s2_y;

  logic signed [31:0]       y32, ay, knee_mag, clip_val;
  logic [DATA_W-1:0]        s3_sample;
  logic                     s3_clip;

  noise_gate #(
    .DATA_W       (DATA_W),
    .HOLD_SAMPLES (HOLD_SAMPLES)
  ) u_gate (
    .clk    (clk),
    .rst    (rst),
    .valid  (in_valid),
    .sample (in_sample),
    .thresh (gate_thresh),
    .open   (s1_open)
  );

  assign prod = PROD_W'(s1_x) * PROD_W'($signed({1'b0, s1_gain}));

  always_comb begin
    y32       = 32'(s2_y);
    ay        = (y32 < 0) ? -y32 : y32;
    knee_mag  = KNEE + ((ay - KNEE) >>> 2);
    clip_val  = '0;
    s3_sample = s2_x;
    s3_clip   = 1'b0;
    case (s2_mode)
      BYPASS: begin
        s3_sample = s2_x;
        s3_clip   = 1'b0;
      end
      SOFT: begin
        if (ay <= KNEE) begin
          clip_val = y32;
        end else begin
          if (knee_mag > LIM) knee_mag = LIM;
          clip_val = (y32 < 0) ? -knee_mag : knee_mag;
          s3_clip  = 1'b1;
        end
        s3_sample = DATA_W'(clip_val);
      end
      default: begin
        clip_val  = sat_sym(y32, DATA_W);
        s3_clip   = (clip_val != y32);
        s3_sample = DATA_W'(clip_val);
      end
    endcase
    if (s2_mode != BYPASS && !s2_open) begin
      s3_sample = '0;
      s3_clip   = 1'b0;
    end
  end

  // Config is captured with each sample so in-flight samples keep their own knobs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      clip_flag  <= 1'b0;
      gate_open  <= 1'b1;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x    <= $signed(in_sample);
        s1_gain <= gain;
        s1_mode <= effect_mode_t'(mode);
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_x    <= s1_x;
        s2_y    <= prod >>> GAIN_FRAC;
        s2_mode <= s1_mode;
        s2_open <= s1_open;
      end
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_sample <= s3_sample;
        clip_flag  <= s3_clip;
        gate_open  <= s2_open;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_effects_chain.sv
// tb_effects_chain: directed + randomized checks of effects_chain against a behavioural model
// Revision 1.0
`default_nettype none

module tb_effects_chain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_sample = '0;
  logic [10:0] gain = 11'd256;
  logic [1:0]  mode = 2'd1;
  logic [14:0] gate_thresh = '0;

  logic        out_valid, clip_flag, gate_open;
  logic [15:0] out_sample;
  logic        out_valid4, clip_flag4, gate_open4;
  logic [15:0] out_sample4;

  always #5 clk = ~clk;

  effects_chain dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample), .gain(gain),
    .mode(mode), .gate_thresh(gate_thresh), .out_valid(out_valid),
    .out_sample(out_sample), .clip_flag(clip_flag), .gate_open(gate_open)
  );

  effects_chain #(.HOLD_SAMPLES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample), .gain(gain),
    .mode(mode), .gate_thresh(gate_thresh), .out_valid(out_valid4),
    .out_sample(out_sample4), .clip_flag(clip_flag4), .gate_open(gate_open4)
  );

  typedef struct {
    int s;
    bit c;
    bit g;
    int cyc;
  } rec_t;

  rec_t got_q[$], got4_q[$], exp_q[$], exp4_q[$];
  rec_t cap_r, cap4_r;
  int   tests = 0, fails = 0, cyc = 0;
  int   cnt_m = 0, cnt4_m = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid) begin
      cap_r.s = int'($signed(out_sample)); cap_r.c = clip_flag; cap_r.g = gate_open; cap_r.cyc = cyc;
      got_q.push_back(cap_r);
    end
    if (out_valid4) begin
      cap4_r.s = int'($signed(out_sample4)); cap4_r.c = clip_flag4; cap4_r.g = gate_open4; cap4_r.cyc = cyc;
      got4_q.push_back(cap4_r);
    end
  end

  // Behavioural model: floor-division gain, then the clip rule on plain integers.
  function automatic void proc(input int x, input int g, input int m, input bit open,
                               output int s, output bit c);
    longint p, y, ay, mm;
    p = longint'(x) * longint'(g);
    if (p >= 0) y = p / 256;
    else        y = -((-p + 255) / 256);
    s = 0; c = 1'b0;
    if (m == 0) begin
      s = x;
    end else if (!open) begin
      s = 0;
    end else if (m == 2) begin
      ay = (y < 0) ? -y : y;
      if (ay <= 16384) s = int'(y);
      else begin
        mm = 16384 + (ay - 16384) / 4;
        if (mm > 32767) mm = 32767;
        s = int'((y < 0) ? -mm : mm);
        c = 1'b1;
      end
    end else begin
      if (y > 32767)       begin s = 32767;  c = 1'b1; end
      else if (y < -32767) begin s = -32767; c = 1'b1; end
      else                 s = int'(y);
    end
  endfunction

  function automatic int gate_next(input int cnt, input int hold, input int x, input int th);
    int mag;
    mag = (x == -32768) ? 32767 : ((x < 0) ? -x : x);
    if (th == 0 || mag >= th) return 0;
    return (cnt + 1 > hold) ? hold : cnt + 1;
  endfunction

  task automatic send(input int x, input int g, input int m, input int th);
    int  s;
    bit  c;
    rec_t e;
    @(negedge clk);
    in_valid = 1'b1; in_sample = 16'(x); gain = 11'(g); mode = 2'(m); gate_thresh = 15'(th);
    cnt_m  = gate_next(cnt_m, 256, x, th);
    cnt4_m = gate_next(cnt4_m, 4, x, th);
    proc(x, g, m, cnt_m != 256, s, c);
    e.s = s; e.c = c; e.g = (cnt_m != 256); e.cyc = cyc + 3;
    exp_q.push_back(e);
    proc(x, g, m, cnt4_m != 4, s, c);
    e.s = s; e.c = c; e.g = (cnt4_m != 4);
    exp4_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    idle(1);
    while ((got_q.size() < n || got4_q.size() < n) && k < 40) begin
      idle(1);
      k++;
    end
    if (k >= 40) begin
      tests++; fails++;
      $display("FAIL wait_out: got %0d/%0d outputs, want %0d", got_q.size(), got4_q.size(), n);
    end
  endtask

  task automatic clear_q();
    got_q.delete(); got4_q.delete(); exp_q.delete(); exp4_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || out_sample !== 16'd0 || clip_flag !== 1'b0 || gate_open !== 1'b1) begin
      fails++;
      $display("FAIL reset: got v=%b s=%0d c=%b g=%b, want v=0 s=0 c=0 g=1",
               out_valid, out_sample, clip_flag, gate_open);
    end
    tests++;
    if (out_valid4 !== 1'b0 || out_sample4 !== 16'd0 || clip_flag4 !== 1'b0 || gate_open4 !== 1'b1) begin
      fails++;
      $display("FAIL reset4: got v=%b s=%0d c=%b g=%b, want v=0 s=0 c=0 g=1",
               out_valid4, out_sample4, clip_flag4, gate_open4);
    end
    rst = 1'b0;
    cnt_m = 0; cnt4_m = 0;
    clear_q();
  endtask

  task automatic test_unity_hard();
    int es[3];
    es = '{1000, -1000, 32767};
    clear_q();
    send(1000, 256, 1, 0); send(-1000, 256, 1, 0); send(32767, 256, 1, 0);
    wait_out(3);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (got_q.size() <= i || got_q[i].s !== es[i] || got_q[i].c !== 1'b0 || got_q[i].cyc !== exp_q[i].cyc) begin
        fails++;
        $display("FAIL unity_hard[%0d]: got s=%0d c=%b cyc=%0d, want s=%0d c=0 cyc=%0d",
                 i, got_q[i].s, got_q[i].c, got_q[i].cyc, es[i], exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_gain_hard();
    int es[3];
    bit ec[3];
    es = '{2000, 32767, -32767};
    ec = '{1'b0, 1'b1, 1'b1};
    clear_q();
    send(1000, 512, 1, 0); send(20000, 512, 1, 0); send(-32768, 512, 3, 0);
    wait_out(3);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (got_q.size() <= i || got_q[i].s !== es[i] || got_q[i].c !== ec[i]) begin
        fails++;
        $display("FAIL gain_hard[%0d]: got s=%0d c=%b, want s=%0d c=%b", i, got_q[i].s, got_q[i].c, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_soft();
    int es[4];
    bit ec[4];
    es = '{18288, -18288, 16000, -1};
    ec = '{1'b1, 1'b1, 1'b0, 1'b0};
    clear_q();
    send(12000, 512, 2, 0); send(-12000, 512, 2, 0); send(8000, 512, 2, 0); send(-1, 128, 2, 0);
    wait_out(4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got_q.size() <= i || got_q[i].s !== es[i] || got_q[i].c !== ec[i]) begin
        fails++;
        $display("FAIL soft[%0d]: got s=%0d c=%b, want s=%0d c=%b", i, got_q[i].s, got_q[i].c, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_gate();
    int es[6];
    bit eg[6];
    es = '{50, 50, 50, 0, 0, 200};
    eg = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    clear_q();
    repeat (5) send(50, 256, 1, 100);
    send(200, 256, 1, 100);
    wait_out(6);
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (got4_q.size() <= i || got4_q[i].s !== es[i] || got4_q[i].g !== eg[i] || got4_q[i].c !== 1'b0) begin
        fails++;
        $display("FAIL gate[%0d]: got s=%0d g=%b c=%b, want s=%0d g=%b c=0",
                 i, got4_q[i].s, got4_q[i].g, got4_q[i].c, es[i], eg[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int xs[6];
    clear_q();
    for (int i = 0; i < 6; i++) begin
      xs[i] = int'($urandom_range(0, 16000)) - 8000;
      send(xs[i], (i < 2) ? 256 : 512, 1, 0);
    end
    wait_out(6);
    idle(5);
    tests++;
    if (got_q.size() !== 6) begin
      fails++;
      $display("FAIL b2b_count: got %0d outputs, want 6", got_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (got_q.size() <= i || got_q[i].s !== ((i < 2) ? xs[i] : 2 * xs[i]) || got_q[i].cyc !== exp_q[i].cyc) begin
        fails++;
        $display("FAIL b2b[%0d]: got s=%0d cyc=%0d, want s=%0d cyc=%0d",
                 i, got_q[i].s, got_q[i].cyc, (i < 2) ? xs[i] : 2 * xs[i], exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_reset_midstream();
    clear_q();
    repeat (4) send(50, 256, 1, 100);
    wait_out(4);
    tests++;
    if (got4_q.size() < 4 || got4_q[3].g !== 1'b0) begin
      fails++;
      $display("FAIL pre_reset_gate: got g=%b, want g=0", gate_open4);
    end
    clear_q();
    send(50, 256, 1, 100); send(60, 256, 1, 100);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_sample = 16'd77;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    cnt_m = 0; cnt4_m = 0;
    idle(6);
    tests++;
    if (got_q.size() !== 0 || got4_q.size() !== 0) begin
      fails++;
      $display("FAIL rst_flush: got %0d/%0d outputs, want 0/0", got_q.size(), got4_q.size());
    end
    tests++;
    if (out_valid4 !== 1'b0 || out_sample4 !== 16'd0 || clip_flag4 !== 1'b0 || gate_open4 !== 1'b1) begin
      fails++;
      $display("FAIL rst_outputs: got v=%b s=%0d c=%b g=%b, want v=0 s=0 c=0 g=1",
               out_valid4, out_sample4, clip_flag4, gate_open4);
    end
    clear_q();
    repeat (3) send(50, 256, 1, 100);
    wait_out(3);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (got4_q.size() <= i || got4_q[i].s !== 50 || got4_q[i].g !== 1'b1) begin
        fails++;
        $display("FAIL rst_cnt[%0d]: got s=%0d g=%b, want s=50 g=1", i, got4_q[i].s, got4_q[i].g);
      end
    end
  endtask

  task automatic test_random();
    int x, th, phase;
    clear_q();
    for (int i = 0; i < 300; i++) begin
      phase = (i / 50) % 3;
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        if (phase == 1 && $urandom_range(0, 9) != 0) x = int'($urandom_range(0, 240)) - 120;
        else x = int'($urandom_range(0, 65535)) - 32768;
        th = (phase == 0) ? 0 : (phase == 1) ? 150 : int'($urandom_range(0, 32767));
        send(x, int'($urandom_range(0, 2047)), int'($urandom_range(0, 3)), th);
      end
    end
    wait_out(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (got_q.size() <= i || got_q[i].s !== exp_q[i].s || got_q[i].c !== exp_q[i].c ||
          got_q[i].g !== exp_q[i].g || got_q[i].cyc !== exp_q[i].cyc) begin
        fails++;
        $display("FAIL random[%0d]: got s=%0d c=%b g=%b cyc=%0d, want s=%0d c=%b g=%b cyc=%0d", i,
                 got_q[i].s, got_q[i].c, got_q[i].g, got_q[i].cyc,
                 exp_q[i].s, exp_q[i].c, exp_q[i].g, exp_q[i].cyc);
      end
      tests++;
      if (got4_q.size() <= i || got4_q[i].s !== exp4_q[i].s || got4_q[i].c !== exp4_q[i].c ||
          got4_q[i].g !== exp4_q[i].g || got4_q[i].cyc !== exp4_q[i].cyc) begin
        fails++;
        $display("FAIL random4[%0d]: got s=%0d c=%b g=%b cyc=%0d, want s=%0d c=%b g=%b cyc=%0d", i,
                 got4_q[i].s, got4_q[i].c, got4_q[i].g, got4_q[i].cyc,
                 exp4_q[i].s, exp4_q[i].c, exp4_q[i].g, exp4_q[i].cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unity_hard();
    test_gain_hard();
    test_soft();
    test_gate();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
